// File: rtl/snake_step.sv
// Snake game-tick stage: on each rising edge of the divided game clock the
// head advances one cell in the steered direction, the body is kept in a
// ring buffer, wall/self collisions are detected and the freed tail cell is
// reported so the drawing logic can erase it.

package snake_pkg;
    typedef enum logic [1:0] {MENU = 2'd0, GAME = 2'd1, PAUSE = 2'd2, OVER = 2'd3} game_mode;
    typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} direction;
endpackage

module snake_step
    import snake_pkg::*;
#(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int MAX_LEN  = 64,
    parameter int INIT_X   = 16,
    parameter int INIT_Y   = 12,
    parameter int INIT_LEN = 3,
    localparam int X_W = $clog2(GRID_W),
    localparam int Y_W = $clog2(GRID_H),
    localparam int L_W = $clog2(MAX_LEN + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_divided,
    input  game_mode       mode,
    input  direction       dir,
    input  logic           grow,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [X_W-1:0] tail_x,
    output logic [Y_W-1:0] tail_y,
    output logic           tail_valid,
    output logic [L_W-1:0] length,
    output logic           step_done,
    output logic           crash
);

    localparam int P_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {IDLE, CALC, SCAN, COMMIT, DEAD} state_t;

    state_t         state;
    state_t         state_next;

    logic [X_W-1:0] ring_x [MAX_LEN];
    logic [Y_W-1:0] ring_y [MAX_LEN];

    logic           prev_div;
    logic           tick;
    logic [P_W-1:0] wr_ptr;
    logic [P_W-1:0] scan_ptr;
    logic [L_W-1:0] scan_cnt;
    logic [X_W-1:0] nxt_x;
    logic [Y_W-1:0] nxt_y;
    direction       step_dir;
    direction       last_dir;
    direction       turn_dir;
    logic           grow_pending;
    logic           step_grow;

    logic [X_W-1:0] cand_x;
    logic [Y_W-1:0] cand_y;
    logic           wall;
    logic           growing;
    logic [L_W-1:0] scan_n;
    logic           hit;
    int             oldest_sum;
    logic [P_W-1:0] oldest_ptr;

    function automatic direction opposite(input direction d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

    function automatic logic [P_W-1:0] ptr_dec(input logic [P_W-1:0] p);
        return (p == '0) ? P_W'(MAX_LEN - 1) : p - P_W'(1);
    endfunction

    function automatic logic [P_W-1:0] ptr_inc(input logic [P_W-1:0] p);
        return (p == P_W'(MAX_LEN - 1)) ? '0 : p + P_W'(1);
    endfunction

    assign tick  = clk_divided & ~prev_div;
    assign crash = (state == DEAD);

    // Candidate head cell for the latched step direction; no wrap-around, edges are walls
    always_comb begin
        cand_x = head_x;
        cand_y = head_y;
        wall   = 1'b0;
        case (step_dir)
            UP:      if (head_y == '0) wall = 1'b1; else cand_y = head_y - Y_W'(1);
            DOWN:    if (head_y == Y_W'(GRID_H - 1)) wall = 1'b1; else cand_y = head_y + Y_W'(1);
            LEFT:    if (head_x == '0) wall = 1'b1; else cand_x = head_x - X_W'(1);
            default: if (head_x == X_W'(GRID_W - 1)) wall = 1'b1; else cand_x = head_x + X_W'(1);
        endcase
    end

    // Steering, scan length and ring-buffer bookkeeping derived from current state
    always_comb begin
        turn_dir = dir;
        if (dir == opposite(last_dir)) turn_dir = last_dir;
        growing    = grow_pending && (length != L_W'(MAX_LEN));
        scan_n     = growing ? length : length - L_W'(1);
        hit        = (ring_x[scan_ptr] == nxt_x) && (ring_y[scan_ptr] == nxt_y);
        oldest_sum = int'(wr_ptr) + MAX_LEN - int'(length);
        if (oldest_sum >= MAX_LEN) oldest_sum = oldest_sum - MAX_LEN;
        oldest_ptr = P_W'(oldest_sum);
    end

    // Next-state logic; leaving GAME always forces a return to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = CALC;
            CALC:    if (wall) state_next = DEAD;
                     else if (scan_n == '0) state_next = COMMIT;
                     else state_next = SCAN;
            SCAN:    if (hit) state_next = DEAD;
                     else if (scan_cnt == L_W'(1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            DEAD:    state_next = DEAD;
            default: state_next = IDLE;
        endcase
        if (mode != GAME) state_next = IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Body ring buffer: preloaded with the vertical initial body, oldest entry at index 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                ring_x[i] <= (i < INIT_LEN) ? X_W'(INIT_X) : '0;
                ring_y[i] <= (i < INIT_LEN) ? Y_W'(INIT_Y + INIT_LEN - 1 - i) : '0;
            end
        end else if (mode != GAME) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                ring_x[i] <= (i < INIT_LEN) ? X_W'(INIT_X) : '0;
                ring_y[i] <= (i < INIT_LEN) ? Y_W'(INIT_Y + INIT_LEN - 1 - i) : '0;
            end
        end else if (state == COMMIT) begin
            ring_x[wr_ptr] <= nxt_x;
            ring_y[wr_ptr] <= nxt_y;
        end
    end

    // Step datapath: latch direction, compute next cell, walk the body, then commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_div     <= 1'b0;
            head_x       <= X_W'(INIT_X);
            head_y       <= Y_W'(INIT_Y);
            length       <= L_W'(INIT_LEN);
            wr_ptr       <= P_W'(INIT_LEN % MAX_LEN);
            scan_ptr     <= '0;
            scan_cnt     <= '0;
            nxt_x        <= '0;
            nxt_y        <= '0;
            step_dir     <= UP;
            last_dir     <= UP;
            grow_pending <= 1'b0;
            step_grow    <= 1'b0;
            tail_x       <= '0;
            tail_y       <= '0;
            tail_valid   <= 1'b0;
            step_done    <= 1'b0;
        end else begin
            prev_div   <= clk_divided;
            tail_valid <= 1'b0;
            step_done  <= 1'b0;
            if (mode != GAME) begin
                head_x       <= X_W'(INIT_X);
                head_y       <= Y_W'(INIT_Y);
                length       <= L_W'(INIT_LEN);
                wr_ptr       <= P_W'(INIT_LEN % MAX_LEN);
                scan_ptr     <= '0;
                scan_cnt     <= '0;
                nxt_x        <= '0;
                nxt_y        <= '0;
                step_dir     <= UP;
                last_dir     <= UP;
                grow_pending <= 1'b0;
                step_grow    <= 1'b0;
                tail_x       <= '0;
                tail_y       <= '0;
            end else begin
                if (grow) grow_pending <= 1'b1;
                case (state)
                    IDLE: if (tick) step_dir <= turn_dir;
                    CALC: begin
                        nxt_x     <= cand_x;
                        nxt_y     <= cand_y;
                        scan_ptr  <= ptr_dec(wr_ptr);
                        scan_cnt  <= scan_n;
                        step_grow <= growing;
                    end
                    SCAN: begin
                        scan_ptr <= ptr_dec(scan_ptr);
                        scan_cnt <= scan_cnt - L_W'(1);
                    end
                    COMMIT: begin
                        wr_ptr       <= ptr_inc(wr_ptr);
                        head_x       <= nxt_x;
                        head_y       <= nxt_y;
                        last_dir     <= step_dir;
                        step_done    <= 1'b1;
                        grow_pending <= grow;
                        if (step_grow) begin
                            length <= length + L_W'(1);
                        end else begin
                            tail_x     <= ring_x[oldest_ptr];
                            tail_y     <= ring_y[oldest_ptr];
                            tail_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
